// File: rtl/rx_phy_pkg.sv
// Shared receive-PHY definitions: alignment lock states and the two 8b/10b
// comma code groups.
package rx_phy_pkg;

  localparam int SYM_W_DEFAULT = 10;

  localparam logic [9:0] COMMA_POS = 10'h0FA;
  localparam logic [9:0] COMMA_NEG = 10'h305;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ALIGNING = 2'd1,
    LOCKED   = 2'd2
  } align_state_e;

endpackage

// File: rtl/rx_align_lock_fsm.sv
// Symbol-alignment lock FSM with hysteresis: counts aligned commas to gain
// lock, tolerates a few off-boundary commas, and drops lock on a long silence.
module rx_align_lock_fsm
  import rx_phy_pkg::*;
#(
  parameter int LOCK_COMMAS  = 4,
  parameter int LOSS_LIMIT   = 3,
  parameter int TIMEOUT_SYMS = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         aligned_comma,
  input  logic         off_comma,
  input  logic         boundary,
  output logic         realign,
  output logic         locked,
  output align_state_e state
);

  localparam int CC_W = $clog2(LOCK_COMMAS + 1);
  localparam int MC_W = $clog2(LOSS_LIMIT + 1);
  localparam int TC_W = $clog2(TIMEOUT_SYMS + 1);

  localparam logic [CC_W-1:0] CC_ONE  = CC_W'(1);
  localparam logic [CC_W-1:0] CC_LAST = CC_W'(LOCK_COMMAS - 1);
  localparam logic [MC_W-1:0] MC_ONE  = MC_W'(1);
  localparam logic [MC_W-1:0] MC_LAST = MC_W'(LOSS_LIMIT - 1);
  localparam logic [TC_W-1:0] TC_ONE  = TC_W'(1);
  localparam logic [TC_W-1:0] TC_LIM  = TC_W'(TIMEOUT_SYMS);

  align_state_e    state_q, state_d;
  logic [CC_W-1:0] comma_cnt_q, comma_cnt_d;
  logic [MC_W-1:0] miss_cnt_q, miss_cnt_d;
  logic [TC_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [TC_W-1:0] tmo_next;
  logic            locked_q, locked_d;

  always_comb begin
    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    realign     = 1'b0;
    tmo_next    = (tmo_cnt_q == TC_LIM) ? tmo_cnt_q : tmo_cnt_q + TC_ONE;

    case (state_q)
      UNLOCKED: begin
        // No boundary exists yet, so every comma arrives as off-boundary.
        if (off_comma) begin
          realign     = 1'b1;
          state_d     = ALIGNING;
          comma_cnt_d = CC_ONE;
          miss_cnt_d  = '0;
          tmo_cnt_d   = '0;
        end
      end
      ALIGNING: begin
        if (off_comma) begin
          realign     = 1'b1;
          comma_cnt_d = CC_ONE;
          tmo_cnt_d   = '0;
        end else if (aligned_comma) begin
          comma_cnt_d = comma_cnt_q + CC_ONE;
          tmo_cnt_d   = '0;
          if (comma_cnt_q == CC_LAST) begin
            state_d    = LOCKED;
            miss_cnt_d = '0;
          end
        end else if (boundary) begin
          if (tmo_next == TC_LIM) begin
            state_d     = UNLOCKED;
            comma_cnt_d = '0;
            miss_cnt_d  = '0;
            tmo_cnt_d   = '0;
          end else begin
            tmo_cnt_d = tmo_next;
          end
        end
      end
      LOCKED: begin
        if (aligned_comma) begin
          miss_cnt_d = '0;
          tmo_cnt_d  = '0;
        end else if (off_comma) begin
          if (miss_cnt_q == MC_LAST) begin
            realign     = 1'b1;
            state_d     = ALIGNING;
            comma_cnt_d = CC_ONE;
            miss_cnt_d  = '0;
            tmo_cnt_d   = '0;
          end else begin
            miss_cnt_d = miss_cnt_q + MC_ONE;
          end
        end else if (boundary) begin
          if (tmo_next == TC_LIM) begin
            state_d     = UNLOCKED;
            comma_cnt_d = '0;
            miss_cnt_d  = '0;
            tmo_cnt_d   = '0;
          end else begin
            tmo_cnt_d = tmo_next;
          end
        end
      end
      default: begin
        state_d     = UNLOCKED;
        comma_cnt_d = '0;
        miss_cnt_d  = '0;
        tmo_cnt_d   = '0;
      end
    endcase

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= UNLOCKED;
      comma_cnt_q <= '0;
      miss_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      comma_cnt_q <= comma_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      locked_q    <= locked_d;
    end
  end

  assign locked = locked_q;
  assign state  = state_q;

endmodule

// File: rtl/rx_symbol_aligner.sv
// Sets the 10-bit symbol boundary from comma pulses and emits aligned symbols
// with a valid strobe once the lock FSM reports LOCKED.
module rx_symbol_aligner
  import rx_phy_pkg::*;
#(
  parameter int SYM_W        = SYM_W_DEFAULT,
  parameter int LOCK_COMMAS  = 4,
  parameter int LOSS_LIMIT   = 3,
  parameter int TIMEOUT_SYMS = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SYM_W-1:0] data_window,
  input  logic             comma_pulse_in,
  output logic [SYM_W-1:0] sym_out,
  output logic             sym_valid,
  output logic             sym_is_comma,
  output logic             locked,
  output logic             realign_pulse
);

  localparam int PH_W = $clog2(SYM_W);
  localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SYM_W - 1);

  logic [PH_W-1:0]  phase_q, phase_d;
  logic [SYM_W-1:0] sym_out_q, sym_out_d;
  logic             sym_valid_q, sym_valid_d;
  logic             sym_is_comma_q, sym_is_comma_d;
  logic             realign_pulse_q, realign_pulse_d;

  align_state_e state;
  logic         boundary, aligned_comma, off_comma, realign, capture;

  assign boundary      = (phase_q == '0) && (state != UNLOCKED);
  assign aligned_comma = comma_pulse_in && boundary;
  assign off_comma     = comma_pulse_in && !boundary;

  rx_align_lock_fsm #(
    .LOCK_COMMAS (LOCK_COMMAS),
    .LOSS_LIMIT  (LOSS_LIMIT),
    .TIMEOUT_SYMS(TIMEOUT_SYMS)
  ) u_fsm (
    .clk          (clk),
    .rst_n        (rst_n),
    .aligned_comma(aligned_comma),
    .off_comma    (off_comma),
    .boundary     (boundary),
    .realign      (realign),
    .locked       (locked),
    .state        (state)
  );

  // The realigning comma is phase 0, so the register takes 1 on that edge.
  always_comb begin
    phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_ONE;
    if (realign) begin
      phase_d = PH_ONE;
    end
  end

  assign capture = boundary && (state == LOCKED);

  always_comb begin
    sym_out_d       = capture ? data_window : sym_out_q;
    sym_valid_d     = capture;
    sym_is_comma_d  = capture && comma_pulse_in;
    realign_pulse_d = realign;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q         <= '0;
      sym_out_q       <= '0;
      sym_valid_q     <= 1'b0;
      sym_is_comma_q  <= 1'b0;
      realign_pulse_q <= 1'b0;
    end else begin
      phase_q         <= phase_d;
      sym_out_q       <= sym_out_d;
      sym_valid_q     <= sym_valid_d;
      sym_is_comma_q  <= sym_is_comma_d;
      realign_pulse_q <= realign_pulse_d;
    end
  end

  assign sym_out       = sym_out_q;
  assign sym_valid     = sym_valid_q;
  assign sym_is_comma  = sym_is_comma_q;
  assign realign_pulse = realign_pulse_q;

endmodule

// File: tb/tb_rx_symbol_aligner.sv
// Scenario bench for rx_symbol_aligner: expected symbols are queued when driven
// at a locked boundary and compared when the strobe appears.
module tb_rx_symbol_aligner;
  import rx_phy_pkg::*;

  localparam int W = 10;
  localparam logic [9:0] FILL = 10'h155;
  localparam logic [9:0] DATA = 10'h2A5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] data_window = '0;
  logic       comma_pulse_in = 1'b0;
  logic [9:0] sym_out;
  logic       sym_valid, sym_is_comma, locked, realign_pulse;

  int errors = 0;
  int checks = 0;
  int rp_count = 0;
  int rp0;
  logic [10:0] sb_q[$];

  always #5 clk = ~clk;

  rx_symbol_aligner dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_window   (data_window),
    .comma_pulse_in(comma_pulse_in),
    .sym_out       (sym_out),
    .sym_valid     (sym_valid),
    .sym_is_comma  (sym_is_comma),
    .locked        (locked),
    .realign_pulse (realign_pulse)
  );

  // Output monitor: samples 1 ns after each edge, ahead of the driver's checks.
  initial begin : monitor
    logic [10:0] exp_e;
    forever begin
      @(posedge clk);
      #1;
      if (realign_pulse) rp_count++;
      if (sym_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe t=%0t sym_out=%h (no symbol expected)", $time, sym_out);
        end else begin
          exp_e = sb_q.pop_front();
          checks += 2;
          if (sym_out !== exp_e[9:0]) begin
            errors++;
            $display("FAIL sb_sym_out t=%0t got=%h want=%h", $time, sym_out, exp_e[9:0]);
          end
          if (sym_is_comma !== exp_e[10]) begin
            errors++;
            $display("FAIL sb_sym_is_comma t=%0t got=%b want=%b", $time, sym_is_comma, exp_e[10]);
          end
        end
      end
    end
  end

  task automatic step(input logic [9:0] w, input logic c);
    data_window    = w;
    comma_pulse_in = c;
    @(posedge clk);
    #2;
  endtask

  // Nine non-boundary cycles (optionally one with a comma at offset off),
  // then the boundary cycle carrying w/c; returns just after that edge.
  task automatic period(input logic [9:0] w, input logic c, input bit exp, input int off);
    for (int i = 1; i < W; i++) step((i == off) ? COMMA_POS : FILL, (i == off));
    if (exp) sb_q.push_back({c, w});
    step(w, c);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    data_window = '0;
    comma_pulse_in = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    sb_q.delete();
    rst_n = 1'b1;
    step(FILL, 1'b0);
  endtask

  task automatic get_lock();
    do_reset();
    step(COMMA_POS, 1'b1);
    repeat (3) period(COMMA_POS, 1'b1, 1'b0, 0);
  endtask

  task automatic chk(input string name, input logic [9:0] got, input logic [9:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_sym_out", sym_out, 10'h000);
    chk("reset_sym_valid", {9'd0, sym_valid}, 10'd0);
    chk("reset_sym_is_comma", {9'd0, sym_is_comma}, 10'd0);
    chk("reset_locked", {9'd0, locked}, 10'd0);
    chk("reset_realign_pulse", {9'd0, realign_pulse}, 10'd0);
    $display("test_reset done");
  endtask

  task automatic test_lock_sequence();
    do_reset();
    repeat (8) step(FILL, 1'b0);
    rp0 = rp_count;
    step(COMMA_POS, 1'b1);
    chk("lock_first_realign", {9'd0, realign_pulse}, 10'd1);
    chk("lock_first_locked", {9'd0, locked}, 10'd0);
    period(COMMA_POS, 1'b1, 1'b0, 0);
    chk("lock_one_pulse", 10'(rp_count - rp0), 10'd1);
    period(COMMA_POS, 1'b1, 1'b0, 0);
    chk("lock_third_locked", {9'd0, locked}, 10'd0);
    period(COMMA_POS, 1'b1, 1'b0, 0);
    chk("lock_fourth_locked", {9'd0, locked}, 10'd1);
    chk("lock_no_sym_on_lock", {9'd0, sym_valid}, 10'd0);
    period(DATA, 1'b0, 1'b1, 0);
    chk("lock_first_valid", {9'd0, sym_valid}, 10'd1);
    chk("lock_data_sym", sym_out, DATA);
    period(COMMA_POS, 1'b1, 1'b1, 0);
    chk("lock_comma_flag", {9'd0, sym_is_comma}, 10'd1);
    step(FILL, 1'b0);
    chk("lock_valid_single", {9'd0, sym_valid}, 10'd0);
    chk("lock_sym_hold", sym_out, COMMA_POS);
    for (int i = 2; i < W; i++) step(FILL, 1'b0);
    sb_q.push_back({1'b0, DATA});
    step(DATA, 1'b0);
    chk("lock_data_flag", {9'd0, sym_is_comma}, 10'd0);
    $display("test_lock_sequence done");
  endtask

  task automatic test_early_comma();
    do_reset();
    step(COMMA_POS, 1'b1);
    repeat (2) period(COMMA_POS, 1'b1, 1'b0, 0);
    rp0 = rp_count;
    repeat (6) step(FILL, 1'b0);
    step(COMMA_POS, 1'b1);
    chk("early_realign", {9'd0, realign_pulse}, 10'd1);
    chk("early_pulse_count", 10'(rp_count - rp0), 10'd1);
    repeat (2) period(COMMA_POS, 1'b1, 1'b0, 0);
    chk("early_not_locked", {9'd0, locked}, 10'd0);
    period(COMMA_POS, 1'b1, 1'b0, 0);
    chk("early_relocked", {9'd0, locked}, 10'd1);
    period(DATA, 1'b0, 1'b1, 0);
    chk("early_new_boundary", {9'd0, sym_valid}, 10'd1);
    $display("test_early_comma done");
  endtask

  task automatic test_loss();
    get_lock();
    rp0 = rp_count;
    repeat (2) period(FILL, 1'b0, 1'b1, 5);
    period(COMMA_POS, 1'b1, 1'b1, 0);
    repeat (2) period(FILL, 1'b0, 1'b1, 5);
    chk("loss_still_locked", {9'd0, locked}, 10'd1);
    chk("loss_no_realign", 10'(rp_count - rp0), 10'd0);
    repeat (4) step(FILL, 1'b0);
    step(COMMA_NEG, 1'b1);
    chk("loss_realign", {9'd0, realign_pulse}, 10'd1);
    chk("loss_locked_fall", {9'd0, locked}, 10'd0);
    repeat (3) period(COMMA_POS, 1'b1, 1'b0, 0);
    chk("loss_relocked", {9'd0, locked}, 10'd1);
    period(DATA, 1'b0, 1'b1, 0);
    chk("loss_moved_boundary", {9'd0, sym_valid}, 10'd1);
    $display("test_loss done");
  endtask

  task automatic test_timeout();
    get_lock();
    rp0 = rp_count;
    repeat (63) period(FILL, 1'b0, 1'b1, 0);
    chk("tmo_locked_at_63", {9'd0, locked}, 10'd1);
    period(DATA, 1'b0, 1'b1, 0);
    chk("tmo_last_valid", {9'd0, sym_valid}, 10'd1);
    chk("tmo_unlocked", {9'd0, locked}, 10'd0);
    chk("tmo_no_realign", 10'(rp_count - rp0), 10'd0);
    repeat (2) period(FILL, 1'b0, 1'b0, 0);
    chk("tmo_no_valid", {9'd0, sym_valid}, 10'd0);
    $display("test_timeout done");
  endtask

  task automatic test_async_reset();
    get_lock();
    period(DATA, 1'b0, 1'b1, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_sym_valid", {9'd0, sym_valid}, 10'd0);
    chk("arst_sym_out", sym_out, 10'h000);
    chk("arst_locked", {9'd0, locked}, 10'd0);
    chk("arst_realign", {9'd0, realign_pulse}, 10'd0);
    chk("arst_is_comma", {9'd0, sym_is_comma}, 10'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) period(FILL, 1'b0, 1'b0, 0);
    step(COMMA_POS, 1'b1);
    repeat (2) period(COMMA_POS, 1'b1, 1'b0, 0);
    chk("arst_not_yet_locked", {9'd0, locked}, 10'd0);
    period(COMMA_POS, 1'b1, 1'b0, 0);
    chk("arst_relocked", {9'd0, locked}, 10'd1);
    period(DATA, 1'b0, 1'b1, 0);
    chk("arst_first_valid", {9'd0, sym_valid}, 10'd1);
    $display("test_async_reset done");
  endtask

  task automatic test_neg_comma();
    get_lock();
    rp0 = rp_count;
    period(COMMA_NEG, 1'b1, 1'b1, 0);
    chk("neg_sym_out", sym_out, COMMA_NEG);
    chk("neg_is_comma", {9'd0, sym_is_comma}, 10'd1);
    period(DATA, 1'b0, 1'b1, 0);
    period(COMMA_POS, 1'b1, 1'b1, 0);
    chk("neg_pos_sym", sym_out, COMMA_POS);
    period(COMMA_NEG, 1'b1, 1'b1, 0);
    chk("neg_sym_out_2", sym_out, COMMA_NEG);
    chk("neg_no_realign", 10'(rp_count - rp0), 10'd0);
    chk("neg_locked", {9'd0, locked}, 10'd1);
    $display("test_neg_comma done");
  endtask

  initial begin : main
    test_reset();
    test_lock_sequence();
    test_early_comma();
    test_loss();
    test_timeout();
    test_async_reset();
    test_neg_comma();
    repeat (2) step(FILL, 1'b0);
    chk("sb_drained", 10'(sb_q.size()), 10'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
